ppu_reg_snoop: RTL and testbench

// - Passive snooper on the SNES PPU B-bus. Watches /PAWR writes, rejects glitch strobes and

---
 rtl/snes_ppu_pkg.sv | 57 +++++
 rtl/sync_edge.sv | 28 ++
 rtl/ppu_reg_snoop.sv | 182 ++++++++++++++++++
 tb/tb_ppu_reg_snoop.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_ppu_pkg.sv
// Shared SNES PPU definitions: B-bus register addresses, snooper FSM states and
// the shadow/frame register layouts used by ppu_reg_snoop.
package snes_ppu_pkg;

  localparam logic [7:0] PPU_INIDISP = 8'h00;
  localparam logic [7:0] PPU_BGMODE  = 8'h05;
  localparam logic [7:0] PPU_M7SEL   = 8'h1A;
  localparam logic [7:0] PPU_SETINI  = 8'h33;

  localparam logic [3:0] BRIGHT_RST = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOW    = 2'd1,
    ST_COMMIT = 2'd2
  } ppu_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } bbus_t;

  typedef struct packed {
    logic [3:0] bright;
    logic       blank;
    logic [2:0] bgmode;
    logic [1:0] m7sel;
    logic       mode7_over;
    logic       interlace;
    logic       overscan;
  } shadow_t;

  typedef struct packed {
    logic [3:0] bright;
    logic       blank;
    logic       mode7_over;
    logic       overscan;
  } frame_t;

  localparam shadow_t SHADOW_RST = '{BRIGHT_RST, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
  localparam frame_t  FRAME_RST  = '{BRIGHT_RST, 1'b0, 1'b0, 1'b0};

  // Mode 7 fills the screen and the outside area is transparent: the OSD must go over it.
  function automatic logic mode7_over(input logic [2:0] bgmode, input logic [1:0] m7sel);
    return (bgmode == 3'd7) && m7sel[1] && !m7sel[0];
  endfunction

  function automatic frame_t frame_of(input shadow_t s);
    frame_t f;
    f.bright     = s.bright;
    f.blank      = s.blank;
    f.mode7_over = s.mode7_over;
    f.overscan   = s.overscan;
    return f;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for one asynchronous level, with registered-history
// rise/fall detection between the second and third stages.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], async_i};

  // NOTE: non-blocking assignments so each stage takes its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign lvl_o  = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/ppu_reg_snoop.sv
// Passive SNES PPU B-bus snooper: filters /PAWR glitches, decodes INIDISP, BGMODE,
// M7SEL and SETINI into live and VBLANK-latched settings for the RGB/OSD stage.
module ppu_reg_snoop
  import snes_ppu_pkg::*;
#(
  parameter int MIN_LOW = 3,
  parameter int CNT_W   = 16
) (
  input  logic             CLK_i,
  input  logic             NRST_i,
  input  logic             PAWR_i,
  input  logic [7:0]       PADDRESS_i,
  input  logic [7:0]       DATA_i,
  input  logic             VBLANK_i,
  output logic [3:0]       brightness_o,
  output logic             blank_o,
  output logic             mode7_over_o,
  output logic             interlace_o,
  output logic             overscan_o,
  output logic [3:0]       f_brightness_o,
  output logic             f_blank_o,
  output logic             f_mode7_over_o,
  output logic             f_overscan_o,
  output logic             wr_stb_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] glitch_cnt_o
);

  localparam int              LC_W      = $clog2(MIN_LOW + 1);
  localparam logic [LC_W-1:0] MIN_LOW_C = LC_W'(MIN_LOW);

  logic pawr_lvl, pawr_rise, pawr_fall;
  logic vb_lvl, vb_rise, vb_fall;

  sync_edge #(.RST_VAL(1'b1)) u_pawr_sync (
    .clk    (CLK_i),
    .rst_n  (NRST_i),
    .async_i(PAWR_i),
    .lvl_o  (pawr_lvl),
    .rise_o (pawr_rise),
    .fall_o (pawr_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_vblank_sync (
    .clk    (CLK_i),
    .rst_n  (NRST_i),
    .async_i(VBLANK_i),
    .lvl_o  (vb_lvl),
    .rise_o (vb_rise),
    .fall_o (vb_fall)
  );

  ppu_state_e       state_q, state_d;
  logic [LC_W-1:0]  lowcnt_q, lowcnt_d;
  logic [1:0]       arm_q, arm_d;
  bbus_t [2:0]      bus_q, bus_d;
  bbus_t            cap_q, cap_d;
  shadow_t          shadow_q, shadow_d;
  frame_t           frame_q, frame_d;
  logic             wr_stb_q, wr_stb_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  logic armed, start_low, do_capture, do_glitch, do_commit;
  logic unused_ok;

  // The PAWR chain leaves reset all-ones; until real samples reach stage 3 a low
  // strobe would look like a fall, so a strobe already low at release is ignored.
  assign armed = (arm_q == 2'd3);

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pawr_fall && armed) state_d = ST_LOW;
      ST_LOW:    if (pawr_rise) state_d = (lowcnt_q >= MIN_LOW_C) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_low  = 1'b0;
    do_capture = 1'b0;
    do_glitch  = 1'b0;
    do_commit  = 1'b0;
    case (state_q)
      ST_IDLE:   start_low = pawr_fall && armed;
      ST_LOW: begin
        do_capture = pawr_rise && (lowcnt_q >= MIN_LOW_C);
        do_glitch  = pawr_rise && (lowcnt_q <  MIN_LOW_C);
      end
      ST_COMMIT: do_commit = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    arm_d    = armed ? arm_q : arm_q + 2'd1;
    bus_d    = {bus_q[1:0], bbus_t'({PADDRESS_i, DATA_i})};
    cap_d    = do_capture ? bus_q[2] : cap_q;
    wr_stb_d = do_commit;

    lowcnt_d = lowcnt_q;
    if (start_low) begin
      lowcnt_d = LC_W'(1);
    end else if (state_q == ST_LOW && !pawr_lvl && lowcnt_q < MIN_LOW_C) begin
      lowcnt_d = lowcnt_q + LC_W'(1);
    end

    shadow_d = shadow_q;
    if (do_commit) begin
      case (cap_q.addr)
        PPU_INIDISP: begin
          shadow_d.bright = cap_q.data[3:0];
          shadow_d.blank  = cap_q.data[7];
        end
        PPU_BGMODE:  shadow_d.bgmode = cap_q.data[2:0];
        PPU_M7SEL:   shadow_d.m7sel  = cap_q.data[7:6];
        PPU_SETINI: begin
          shadow_d.interlace = cap_q.data[0];
          shadow_d.overscan  = cap_q.data[2];
        end
        default: ;
      endcase
      shadow_d.mode7_over = mode7_over(shadow_d.bgmode, shadow_d.m7sel);
    end

    // Snapshot the pre-edge live value: a commit on this same edge waits a frame.
    frame_d = vb_rise ? frame_of(shadow_q) : frame_q;

    wr_cnt_d = do_commit ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;

    glitch_cnt_d = glitch_cnt_q;
    if (do_glitch && glitch_cnt_q != '1) glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) begin
      arm_q        <= 2'd0;
      lowcnt_q     <= '0;
      bus_q        <= '0;
      cap_q        <= '0;
      shadow_q     <= SHADOW_RST;
      frame_q      <= FRAME_RST;
      wr_stb_q     <= 1'b0;
      wr_cnt_q     <= '0;
      glitch_cnt_q <= '0;
    end else begin
      arm_q        <= arm_d;
      lowcnt_q     <= lowcnt_d;
      bus_q        <= bus_d;
      cap_q        <= cap_d;
      shadow_q     <= shadow_d;
      frame_q      <= frame_d;
      wr_stb_q     <= wr_stb_d;
      wr_cnt_q     <= wr_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign unused_ok = ^{vb_lvl, vb_fall, cap_q.data[5:4]};

  assign brightness_o   = shadow_q.bright;
  assign blank_o        = shadow_q.blank;
  assign mode7_over_o   = shadow_q.mode7_over;
  assign interlace_o    = shadow_q.interlace;
  assign overscan_o     = shadow_q.overscan;
  assign f_brightness_o = frame_q.bright;
  assign f_blank_o      = frame_q.blank;
  assign f_mode7_over_o = frame_q.mode7_over;
  assign f_overscan_o   = frame_q.overscan;
  assign wr_stb_o       = wr_stb_q;
  assign wr_cnt_o       = wr_cnt_q;
  assign glitch_cnt_o   = glitch_cnt_q;

endmodule

// File: tb/tb_ppu_reg_snoop.sv
// Scoreboard bench for ppu_reg_snoop: the stimulus side updates a register-level
// model and queues the expected live state; a monitor checks it on every wr_stb_o.
module tb_ppu_reg_snoop;
  import snes_ppu_pkg::*;

  localparam int MIN_LOW = 3;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             nrst, pawr, vblank;
  logic [7:0]       addr, data;
  logic [3:0]       brightness_o, f_brightness_o;
  logic             blank_o, mode7_over_o, interlace_o, overscan_o;
  logic             f_blank_o, f_mode7_over_o, f_overscan_o, wr_stb_o;
  logic [CNT_W-1:0] wr_cnt_o, glitch_cnt_o;

  always #5 clk = ~clk;

  ppu_reg_snoop #(.MIN_LOW(MIN_LOW), .CNT_W(CNT_W)) dut (
    .CLK_i         (clk),
    .NRST_i        (nrst),
    .PAWR_i        (pawr),
    .PADDRESS_i    (addr),
    .DATA_i        (data),
    .VBLANK_i      (vblank),
    .brightness_o  (brightness_o),
    .blank_o       (blank_o),
    .mode7_over_o  (mode7_over_o),
    .interlace_o   (interlace_o),
    .overscan_o    (overscan_o),
    .f_brightness_o(f_brightness_o),
    .f_blank_o     (f_blank_o),
    .f_mode7_over_o(f_mode7_over_o),
    .f_overscan_o  (f_overscan_o),
    .wr_stb_o      (wr_stb_o),
    .wr_cnt_o      (wr_cnt_o),
    .glitch_cnt_o  (glitch_cnt_o)
  );

  typedef struct {
    logic [3:0]       bright;
    logic             blank;
    logic             m7;
    logic             inter;
    logic             over;
    logic [CNT_W-1:0] wr_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: PPU register values as the CPU wrote them.
  logic [3:0]       m_bright, mf_bright;
  logic             m_blank, m_inter, m_over, mf_blank, mf_m7, mf_over;
  logic [2:0]       m_bgmode;
  logic [1:0]       m_m7sel;
  logic [CNT_W-1:0] m_wr_cnt, m_glitch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_m7();
    return (m_bgmode == 3'd7) && (m_m7sel == 2'b10);
  endfunction

  task automatic model_reset();
    m_bright = 4'hF; m_blank = 1'b0; m_bgmode = 3'd0; m_m7sel = 2'd0;
    m_inter = 1'b0;  m_over = 1'b0;
    mf_bright = 4'hF; mf_blank = 1'b0; mf_m7 = 1'b0; mf_over = 1'b0;
    m_wr_cnt = '0; m_glitch = '0;
    sb_q.delete();
  endtask

  task automatic model_snapshot();
    mf_bright = m_bright; mf_blank = m_blank; mf_m7 = model_m7(); mf_over = m_over;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    case (a)
      PPU_INIDISP: begin m_bright = d[3:0]; m_blank = d[7]; end
      PPU_BGMODE:  m_bgmode = d[2:0];
      PPU_M7SEL:   m_m7sel = d[7:6];
      PPU_SETINI:  begin m_inter = d[0]; m_over = d[2]; end
      default: ;
    endcase
    m_wr_cnt = m_wr_cnt + CNT_W'(1);
    e.bright = m_bright; e.blank = m_blank; e.m7 = model_m7();
    e.inter = m_inter; e.over = m_over; e.wr_cnt = m_wr_cnt;
    sb_q.push_back(e);
  endtask

  // Drive one strobe: low_n sampled low cycles (bus random until the last), high_n high cycles.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int low_n,
                          input int high_n, input bit vb_same);
    for (int i = 0; i < low_n; i++) begin
      @(negedge clk);
      pawr = 1'b0;
      if (i == low_n - 1) begin addr = a; data = d; end
      else begin addr = 8'($urandom); data = 8'($urandom); end
    end
    @(negedge clk);
    pawr = 1'b1; addr = 8'($urandom); data = 8'($urandom);
    if (low_n >= MIN_LOW) begin
      if (vb_same) model_snapshot();
      model_write(a, d);
    end else if (m_glitch != '1) begin
      m_glitch = m_glitch + CNT_W'(1);
    end
    for (int i = 1; i < high_n; i++) begin
      @(negedge clk);
      if (vb_same && i == 1) vblank = 1'b1;
    end
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vblank = 1'b1;
    model_snapshot();
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bright"},   32'(brightness_o),   32'(m_bright));
    check({tag, "_blank"},    32'(blank_o),        32'(m_blank));
    check({tag, "_m7"},       32'(mode7_over_o),   32'(model_m7()));
    check({tag, "_inter"},    32'(interlace_o),    32'(m_inter));
    check({tag, "_over"},     32'(overscan_o),     32'(m_over));
    check({tag, "_f_bright"}, 32'(f_brightness_o), 32'(mf_bright));
    check({tag, "_f_blank"},  32'(f_blank_o),      32'(mf_blank));
    check({tag, "_f_m7"},     32'(f_mode7_over_o), 32'(mf_m7));
    check({tag, "_f_over"},   32'(f_overscan_o),   32'(mf_over));
    check({tag, "_stb"},      32'(wr_stb_o),       32'(0));
    check({tag, "_wr_cnt"},   32'(wr_cnt_o),       32'(m_wr_cnt));
    check({tag, "_glitch"},   32'(glitch_cnt_o),   32'(m_glitch));
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return PPU_INIDISP;
      1:       return PPU_BGMODE;
      2:       return PPU_M7SEL;
      3:       return PPU_SETINI;
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: every accepted write must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_stb_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_stb actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_bright", 32'(brightness_o), 32'(e.bright));
          check("sb_blank",  32'(blank_o),      32'(e.blank));
          check("sb_m7",     32'(mode7_over_o), 32'(e.m7));
          check("sb_inter",  32'(interlace_o),  32'(e.inter));
          check("sb_over",   32'(overscan_o),   32'(e.over));
          check("sb_wr_cnt", 32'(wr_cnt_o),     32'(e.wr_cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    nrst = 1'b0; pawr = 1'b1; vblank = 1'b0; addr = 8'h00; data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    check_state("reset");

    // Accepted $00=8A with 6 low cycles: outputs move exactly at edge k+3.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pawr = 1'b0;
      addr = (i == 5) ? 8'h00 : 8'($urandom);
      data = (i == 5) ? 8'h8A : 8'($urandom);
    end
    @(negedge clk);
    pawr = 1'b1; addr = 8'($urandom); data = 8'($urandom);
    model_write(8'h00, 8'h8A);
    repeat (3) @(posedge clk);
    #1;
    check("lat_k2_bright", 32'(brightness_o), 32'h0F);
    check("lat_k2_stb",    32'(wr_stb_o),     32'(0));
    @(posedge clk);
    #1;
    check("lat_k3_bright", 32'(brightness_o), 32'h0A);
    check("lat_k3_blank",  32'(blank_o),      32'(1));
    check("lat_k3_stb",    32'(wr_stb_o),     32'(1));
    check("lat_k3_wr_cnt", 32'(wr_cnt_o),     32'(1));
    repeat (3) @(negedge clk);

    // Two-cycle strobe is a glitch.
    do_write(8'h00, 8'h05, 2, 3, 1'b0);
    repeat (4) @(negedge clk);
    check("glitch_cnt_one", 32'(glitch_cnt_o), 32'(1));
    check_state("glitch");

    // Commit on the same edge as the VBLANK rise reaches f_* one frame later.
    do_write(8'h00, 8'h0F, 4, 3, 1'b0);
    do_write(8'h00, 8'h03, 3, 3, 1'b1);
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    check("same_edge_f_bright", 32'(f_brightness_o), 32'h0F);
    check_state("same_edge");
    vblank_pulse();
    check("next_vb_f_bright", 32'(f_brightness_o), 32'h03);

    // Mode-7 overlay flag, live and frame-latched.
    do_write(PPU_BGMODE, 8'h07, 3, 3, 1'b0);
    do_write(PPU_M7SEL,  8'h80, 3, 3, 1'b0);
    repeat (4) @(negedge clk);
    check("m7_on",      32'(mode7_over_o),   32'(1));
    check("m7_f_wait",  32'(f_mode7_over_o), 32'(0));
    vblank_pulse();
    check("m7_f_on",    32'(f_mode7_over_o), 32'(1));
    do_write(PPU_M7SEL, 8'hC0, 3, 3, 1'b0);
    repeat (4) @(negedge clk);
    check("m7_off",     32'(mode7_over_o),   32'(0));
    check("m7_f_hold",  32'(f_mode7_over_o), 32'(1));
    vblank_pulse();
    check("m7_f_off",   32'(f_mode7_over_o), 32'(0));
    check_state("m7");

    // Random traffic: mixed strobe widths, decoded and undecoded addresses, frame pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) vblank_pulse();
      else do_write(pick_addr(), 8'($urandom), int'($urandom_range(1, 6)),
                    int'($urandom_range(3, 5)), 1'b0);
    end
    repeat (5) @(negedge clk);
    check_state("random");

    // Undecoded writes until the write counter wraps.
    n = 256 - int'(m_wr_cnt);
    for (int i = 0; i < n; i++) do_write(8'hFF, 8'($urandom), 3, 3, 1'b0);
    repeat (5) @(negedge clk);
    check("wrap_wr_cnt", 32'(wr_cnt_o), 32'(0));
    check_state("wrap");

    // Glitch counter saturates.
    n = 256 - int'(m_glitch) + 3;
    for (int i = 0; i < n; i++) do_write(8'h00, 8'($urandom), int'($urandom_range(1, 2)), 3, 1'b0);
    repeat (5) @(negedge clk);
    check("glitch_sat", 32'(glitch_cnt_o), 32'hFF);
    check_state("glitch_sat");

    // Reset during the low phase of a $33=05 write, /PAWR still low at release.
    @(negedge clk);
    pawr = 1'b0; addr = PPU_SETINI; data = 8'h05;
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("mid_rst");
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    pawr = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_inter", 32'(interlace_o), 32'(0));
    check_state("post_rst");

    repeat (10) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
